chaos_key_loader: RTL and testbench
===================================

Name: chaos_key_loader

Overview:
- Supplies the 96-bit key consumed by the keyed ALU datapath.
- Takes bytes from the UART receiver and assembles a framed key: header, 12 key bytes, checksum.
- Commits the key atomically to the ALU only when the pipeline signals a safe point.
- Sits between the UART RX block and the execute stage.

Parameters:
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 100000, max clk cycles allowed between bytes inside a frame; minimum value 2.
- RESET_KEY, 96'h0, value driven on key out of reset.

Ports:
- clk  in  1  system clock
- Rst  in  1  asynchronous active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
- commit_ok  in  1  high when the pipeline has no ALU op in flight; key may change
- key  out  96  key to ALU; changes only on commit
- key_valid  out  1  high once any frame has been committed since reset
- busy  out  1  high in any state other than IDLE
- frame_ok  out  1  one-cycle pulse on the cycle key updates
- frame_err  out  1  one-cycle pulse on the cycle a frame is rejected
- err_code  out  2  cause of the last error, held until the next error or reset: 01 checksum, 10 timeout, 11 locked (lock feature only), 00 none

Behaviour:
- Reset (async, Rst=1) drives:
  - key=RESET_KEY, key_valid=0, busy=0, frame_ok=0, frame_err=0, err_code=00
  - state=IDLE; shadow register, byte counter, checksum and timer cleared
- Reset mid-frame or mid-commit discards the partial frame; key returns to RESET_KEY.
- States:
  - IDLE: on rx_valid with rx_data==HEADER -> KEY, clear byte counter, checksum and timer. Other bytes are ignored silently (no error).
  - KEY: each rx_valid stores the byte at shadow[95-8*cnt -: 8] (first byte = MSB) and XORs it into the checksum. After the byte with cnt==11 -> CHK.
  - CHK: next rx_valid is the checksum byte.
    - If it equals the XOR of the 12 key bytes -> COMMIT.
    - Otherwise -> IDLE, frame_err pulse, err_code=01; key unchanged.
  - COMMIT: on the first cycle commit_ok=1, key<=shadow, key_valid<=1, frame_ok pulse, -> IDLE. This can be the entry cycle's successor at the earliest. rx_valid is ignored while in COMMIT (bytes dropped).
- Timer:
  - Counts cycles in KEY and CHK; reset on each rx_valid.
  - Reaching TIMEOUT_CYCLES without a byte -> IDLE, frame_err pulse, err_code=10.
  - Not active in COMMIT, which waits indefinitely.
- A HEADER value inside KEY/CHK is treated as data, not a restart.
- If rx_valid and timeout occur in the same cycle, the byte wins and the timer resets.
- Latency: frame_ok and the key update occur 1 cycle after the checksum strobe when commit_ok is already high.
- key never changes on any cycle other than a frame_ok cycle or reset.
- Outputs are registered; frame_ok and frame_err are never high together.

Optional Feature:
- CHAOS_KEY_LOCK_EN defined:
  - After the first successful commit, a lock bit is set (cleared only by Rst).
  - A HEADER byte received in IDLE while locked produces a frame_err pulse with err_code=11, and the state stays IDLE. No further key updates are possible.
- Not defined: the lock logic is absent; frames are accepted indefinitely and err_code never reads 11.

Test Plan:
- Clean load: A5, 00 11 22 33 44 55 66 77 88 99 AA BB, then checksum 0x00 with commit_ok=1 -> key=96'h00112233445566778899AABB, key_valid=1, frame_ok pulses 1 cycle after the checksum byte.
- Bad checksum: same frame with checksum 0x5A -> frame_err pulse, err_code=01, key stays 96'h0, key_valid=0, busy=0 afterward.
- Commit deferral: a valid frame with key bytes 01..0C and checksum 0x0C, commit_ok held 0 for 20 cycles then 1 -> key unchanged and busy=1 during the wait. key=96'h0102030405060708090A0B0C on the cycle after commit_ok rises; bytes sent during the wait are dropped.
- Timeout: TIMEOUT_CYCLES=50; A5 followed by 5 bytes then silence -> frame_err at 50 cycles after the 5th byte, err_code=10. A subsequent full valid frame loads correctly.
- Async reset mid-frame: Rst asserted after byte 6 of a frame, following an earlier committed key -> key=RESET_KEY and key_valid=0 immediately without a clock edge. A fresh frame then loads.
- Lock (with CHAOS_KEY_LOCK_EN): a first frame commits; a second valid frame with a different key -> frame_err on its header, err_code=11, key retains the first value.

Source files
------------

// File: rtl/chaos_key_loader.sv
// Assembles a framed 96-bit key (header, 12 key bytes, XOR checksum) from UART bytes and commits it at a pipeline safe point.
// Optional CHAOS_KEY_LOCK_EN: after the first commit, any further frame header is rejected until reset.
module chaos_key_loader #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [95:0] RESET_KEY      = 96'h0
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        commit_ok,
  output logic [95:0] key,
  output logic        key_valid,
  output logic        busy,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, KEY, CHK, COMMIT} state_t;

  state_t        state, state_nx;
  logic [95:0]   shadow, shadow_nx;
  logic [95:0]   key_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [7:0]    csum, csum_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          key_valid_nx, frame_ok_nx, frame_err_nx;
  logic [1:0]    err_code_nx;
  logic          timeout;
  logic          header_blocked;
  logic          commit_now;

`ifdef CHAOS_KEY_LOCK_EN
  logic locked;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      locked <= 1'b0;
    end else if (commit_now) begin
      locked <= 1'b1;
    end
  end

  assign header_blocked = locked;
`else
  assign header_blocked = 1'b0;
`endif

  // The last silent cycle before the limit; the timer is cleared by every byte.
  assign timeout    = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign commit_now = (state == COMMIT) && commit_ok;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      shadow    <= '0;
      cnt       <= '0;
      csum      <= '0;
      timer     <= '0;
      key       <= RESET_KEY;
      key_valid <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= state_nx;
      shadow    <= shadow_nx;
      cnt       <= cnt_nx;
      csum      <= csum_nx;
      timer     <= timer_nx;
      key       <= key_nx;
      key_valid <= key_valid_nx;
      frame_ok  <= frame_ok_nx;
      frame_err <= frame_err_nx;
      err_code  <= err_code_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    shadow_nx    = shadow;
    cnt_nx       = cnt;
    csum_nx      = csum;
    timer_nx     = timer;
    key_nx       = key;
    key_valid_nx = key_valid;
    frame_ok_nx  = 1'b0;
    frame_err_nx = 1'b0;
    err_code_nx  = err_code;

    case (state)
      IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          if (header_blocked) begin
            frame_err_nx = 1'b1;
            err_code_nx  = 2'b11;
          end else begin
            state_nx  = KEY;
            shadow_nx = '0;
            cnt_nx    = '0;
            csum_nx   = '0;
            timer_nx  = '0;
          end
        end
      end

      KEY: begin
        if (rx_valid) begin
          shadow_nx[95 - 8*cnt -: 8] = rx_data;
          csum_nx  = csum ^ rx_data;
          timer_nx = '0;
          if (cnt == 4'd11) begin
            state_nx = CHK;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end else if (timeout) begin
          state_nx     = IDLE;
          frame_err_nx = 1'b1;
          err_code_nx  = 2'b10;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      CHK: begin
        if (rx_valid) begin
          timer_nx = '0;
          if (rx_data == csum) begin
            state_nx = COMMIT;
          end else begin
            state_nx     = IDLE;
            frame_err_nx = 1'b1;
            err_code_nx  = 2'b01;
          end
        end else if (timeout) begin
          state_nx     = IDLE;
          frame_err_nx = 1'b1;
          err_code_nx  = 2'b10;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      COMMIT: begin
        if (commit_ok) begin
          key_nx       = shadow;
          key_valid_nx = 1'b1;
          frame_ok_nx  = 1'b1;
          state_nx     = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chaos_key_loader.sv
// Directed bench for chaos_key_loader: a queue-based frame model checked every cycle, plus literal expectations.
module tb_chaos_key_loader;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TO  = 50;
`ifdef CHAOS_KEY_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        commit_ok = 1'b1;
  logic [95:0] key;
  logic        key_valid, busy, frame_ok, frame_err;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;

  chaos_key_loader #(.HEADER(HDR), .TIMEOUT_CYCLES(TO), .RESET_KEY(96'h0)) dut (
    .clk(clk), .Rst(Rst), .rx_data(rx_data), .rx_valid(rx_valid), .commit_ok(commit_ok),
    .key(key), .key_valid(key_valid), .busy(busy), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Frame model: phase 0 idle, 1 collecting bytes, 2 waiting for commit_ok.
  int          m_phase;
  logic [7:0]  m_q[$];
  int          m_silent;
  logic [95:0] m_key;
  logic        m_kv, m_fok, m_ferr;
  logic [1:0]  m_code;
  bit          m_locked;

  task automatic m_reset();
    m_phase = 0; m_q.delete(); m_silent = 0; m_key = 96'h0;
    m_kv = 0; m_fok = 0; m_ferr = 0; m_code = 2'b00; m_locked = 0;
  endtask

  function automatic logic [7:0] q_xor();
    logic [7:0] x = 8'h00;
    foreach (m_q[i]) x = x ^ m_q[i];
    return x;
  endfunction

  task automatic m_step();
    m_fok = 0; m_ferr = 0;
    case (m_phase)
      0: if (rx_valid && rx_data == HDR) begin
        if (LOCK && m_locked) begin
          m_ferr = 1; m_code = 2'b11;
        end else begin
          m_phase = 1; m_q.delete(); m_silent = 0;
        end
      end
      1: if (rx_valid) begin
        m_silent = 0;
        if (m_q.size() < 12) m_q.push_back(rx_data);
        else if (q_xor() == rx_data) m_phase = 2;
        else begin m_phase = 0; m_ferr = 1; m_code = 2'b01; end
      end else begin
        m_silent++;
        if (m_silent == TO) begin m_phase = 0; m_ferr = 1; m_code = 2'b10; end
      end
      default: if (commit_ok) begin
        m_key = 96'h0;
        foreach (m_q[i]) m_key = {m_key[87:0], m_q[i]};
        m_kv = 1; m_fok = 1; m_phase = 0; m_locked = 1;
      end
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge Rst);
      if (Rst) m_reset();
      else m_step();
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("key", key, m_key);
      check("key_valid", 96'(key_valid), 96'(m_kv));
      check("busy", 96'(busy), 96'(m_phase != 0));
      check("frame_ok", 96'(frame_ok), 96'(m_fok));
      check("frame_err", 96'(frame_err), 96'(m_ferr));
      check("err_code", 96'(err_code), 96'(m_code));
    end
  end

  // Called at a negedge; returns at the negedge after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] key_xor(input logic [95:0] k);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 12; i++) x = x ^ k[95 - 8*i -: 8];
    return x;
  endfunction

  task automatic send_body(input logic [95:0] k, input logic [7:0] c);
    for (int i = 0; i < 12; i++) send_byte(k[95 - 8*i -: 8]);
    send_byte(c);
  endtask

  localparam logic [95:0] K1 = 96'h00112233445566778899AABB;
  localparam logic [95:0] K2 = 96'h0102030405060708090A0B0C;
  localparam logic [95:0] K3 = 96'h123456789ABCDEF013579BDF;
  localparam logic [95:0] K4 = 96'hCAFEF00D0BADBEEF10203040;
  localparam logic [95:0] K5 = 96'h0F1E2D3C4B5A69788796B4C3;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_key", key, 96'h0);
    check("rst_key_valid", 96'(key_valid), 96'h0);
    check("rst_busy", 96'(busy), 96'h0);
    check("rst_err_code", 96'(err_code), 96'h0);
    Rst = 1'b0;
    @(negedge clk);

    $display("[TB] bad checksum");
    send_byte(HDR); send_body(K1, 8'h5A);
    check("badchk_frame_err", 96'(frame_err), 96'h1);
    check("badchk_err_code", 96'(err_code), 96'h1);
    @(negedge clk);
    check("badchk_key", key, 96'h0);
    check("badchk_key_valid", 96'(key_valid), 96'h0);
    check("badchk_busy", 96'(busy), 96'h0);

    $display("[TB] clean load");
    send_byte(HDR); send_body(K1, 8'h00);
    @(negedge clk);
    check("clean_frame_ok", 96'(frame_ok), 96'h1);
    check("clean_key", key, K1);
    check("clean_key_valid", 96'(key_valid), 96'h1);

    $display("[TB] commit deferral");
    commit_ok = 1'b0;
    send_byte(HDR); send_body(K2, 8'h0C);
    check("defer_busy", 96'(busy), 96'h1);
    send_byte(HDR); send_byte(8'h77);
    repeat (18) @(negedge clk);
    check("defer_key_held", key, K1);
    check("defer_busy_end", 96'(busy), 96'h1);
    commit_ok = 1'b1;
    @(negedge clk);
    check("defer_key", key, K2);
    check("defer_frame_ok", 96'(frame_ok), 96'h1);
    @(negedge clk);

    $display("[TB] timeout");
    send_byte(HDR);
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
    repeat (49) @(negedge clk);
    check("to_not_yet", 96'(frame_err), 96'h0);
    @(negedge clk);
    check("to_frame_err", 96'(frame_err), 96'h1);
    check("to_err_code", 96'(err_code), 96'h2);
    send_byte(HDR); send_body(K3, key_xor(K3));
    @(negedge clk);
    check("to_reload_key", key, K3);

    $display("[TB] async reset mid-frame");
    send_byte(HDR);
    for (int i = 0; i < 6; i++) send_byte(8'h20 + 8'(i));
    #3 Rst = 1'b1;
    #1;
    check("arst_key", key, 96'h0);
    check("arst_key_valid", 96'(key_valid), 96'h0);
    @(negedge clk);
    Rst = 1'b0;
    @(negedge clk);
    send_byte(HDR); send_body(K4, key_xor(K4));
    @(negedge clk);
    check("arst_reload_key", key, K4);

    $display("[TB] second frame after a commit");
    send_byte(HDR);
    if (LOCK) begin
      check("lock_frame_err", 96'(frame_err), 96'h1);
      check("lock_err_code", 96'(err_code), 96'h3);
    end
    send_body(K5, key_xor(K5));
    @(negedge clk);
    check("second_key", key, LOCK ? K4 : K5);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
